// File: rtl/core_fetch.sv
// Instruction fetch stage: keeps the fetch PC, issues pipelined imem requests under a credit
// limit, buffers responses with their PCs and hands them to decode; redirects squash wrong-path work.
module core_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        d_valid,
   input  logic        d_ready,
   output logic [31:0] d_pc,
   output logic [31:0] d_ir
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   pc_q;
   logic [31:0]   rsp_pc_q;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] cnt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   fifo_pc [DEPTH];
   logic [31:0]   fifo_ir [DEPTH];

   logic [CW:0]   credit_used;
   logic          req_fire;
   logic          push;
   logic          pop;
   logic [31:0]   redir_target;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + AW'(1);
   endfunction

   assign credit_used    = (CW + 1)'(out_cnt) + (CW + 1)'(cnt);
   assign imem_req_valid = rst & ~redirect_valid & (credit_used < DEPTH_W);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign push           = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);
   assign d_valid        = (cnt != '0);
   assign pop            = d_valid & d_ready;
   assign d_pc           = fifo_pc[rd_ptr];
   assign d_ir           = fifo_ir[rd_ptr];
   assign redir_target   = {redirect_pc[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         out_cnt  <= '0;
         drop_cnt <= '0;
         cnt      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_pc[i] <= '0;
            fifo_ir[i] <= '0;
         end
      end else begin
         out_cnt <= out_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
         if (redirect_valid) begin
            pc_q     <= redir_target;
            rsp_pc_q <= redir_target;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            // Everything still outstanding after this cycle is wrong-path; drop_cnt is
            // always a subset of out_cnt, so it is replaced rather than added to.
            drop_cnt <= out_cnt - CW'(imem_rsp_valid);
         end else begin
            if (req_fire)
               pc_q <= pc_q + 32'd4;
            if (imem_rsp_valid && (drop_cnt != '0))
               drop_cnt <= drop_cnt - CW'(1);
            if (push) begin
               fifo_pc[wr_ptr] <= rsp_pc_q;
               fifo_ir[wr_ptr] <= imem_rsp_data;
               wr_ptr          <= ptr_inc(wr_ptr);
               rsp_pc_q        <= rsp_pc_q + 32'd4;
            end
            if (pop)
               rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CW'(push) - CW'(pop);
         end
      end
   end

endmodule
